// File: rtl/jb_fh_radio_frame_sched.sv
// Per-carrier 10 ms DL/UL radio-frame start strobe generator, phase-locked to the
// fronthaul 1PPS and gated by fronthaul readiness.
module jb_fh_radio_frame_sched #(
  parameter int unsigned N_CARRIERS  = 2,
  parameter int unsigned N_ETH_PORTS = 2,
  parameter int unsigned NS_PER_CLK  = 4,
  parameter int unsigned FRAME_NS    = 10000000,
  parameter int unsigned OFS_W       = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_enable,
  input  logic [N_CARRIERS-1:0]       cfg_carrier_en,
  input  logic [N_CARRIERS*OFS_W-1:0] cfg_dl_offset,
  input  logic [N_CARRIERS*OFS_W-1:0] cfg_ul_offset,
  input  logic                        sticky_clr,
  input  logic                        one_pps,
  input  logic [N_ETH_PORTS-1:0]      eth_fram_reset_active,
  input  logic                        ul_fram_ready,
  input  logic                        dl_defm_ready,
  output logic [N_CARRIERS-1:0]       dl_radio_start_10ms,
  output logic [N_CARRIERS-1:0]       ul_radio_start_10ms,
  output logic [9:0]                  frame_cnt,
  output logic [1:0]                  sched_state,
  output logic                        pps_slip,
  output logic                        cfg_err
);

  localparam int unsigned PW = OFS_W + 1;
  localparam logic [PW-1:0]    W_FRAME = PW'(FRAME_NS);
  localparam logic [PW-1:0]    W_STEP  = PW'(NS_PER_CLK);
  localparam logic [OFS_W-1:0] W_LAST  = OFS_W'(FRAME_NS - NS_PER_CLK);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_READY, S_WAIT_PPS, S_RUN} state_t;

  state_t                 r_state;
  logic                   r_pps_d;
  logic [OFS_W-1:0]       r_frame_ns;
  logic [OFS_W-1:0]       r_dl_ofs [N_CARRIERS];
  logic [OFS_W-1:0]       r_ul_ofs [N_CARRIERS];
  logic [N_CARRIERS-1:0]  r_dl_hit;
  logic [N_CARRIERS-1:0]  r_ul_hit;

  logic                   w_pps_edge;
  logic                   w_ok;
  logic [PW-1:0]          w_sum;
  logic                   w_wrap;
  logic [OFS_W-1:0]       w_next;
  logic [OFS_W-1:0]       w_dl_sat [N_CARRIERS];
  logic [OFS_W-1:0]       w_ul_sat [N_CARRIERS];
  logic [N_CARRIERS-1:0]  w_dl_cross;
  logic [N_CARRIERS-1:0]  w_ul_cross;
  logic [N_CARRIERS-1:0]  w_dl_zero;
  logic [N_CARRIERS-1:0]  w_ul_zero;
  logic                   w_cfg_bad;
  logic                   w_slip_set;
  logic                   w_err_set;

  // Offset o lies in the half-open phase interval (p, n], modulo the frame.
  function automatic logic f_cross(input logic [OFS_W-1:0] p, input logic [OFS_W-1:0] n,
                                   input logic [OFS_W-1:0] o);
    if (n > p) return (o > p) && (o <= n);
    else       return (o > p) || (o <= n);
  endfunction

  function automatic logic [OFS_W-1:0] f_sat(input logic [OFS_W-1:0] o);
    return ({1'b0, o} >= W_FRAME) ? W_LAST : o;
  endfunction

  assign w_pps_edge = one_pps & ~r_pps_d;
  assign w_ok       = dl_defm_ready & ul_fram_ready & ~|eth_fram_reset_active;
  assign w_sum      = {1'b0, r_frame_ns} + W_STEP;
  assign w_wrap     = (w_sum >= W_FRAME);
  assign w_next     = (w_pps_edge || w_wrap) ? '0 : w_sum[OFS_W-1:0];
  assign w_slip_set = (r_state == S_RUN) && cfg_enable && w_ok && w_pps_edge && (r_frame_ns != W_LAST);
  assign w_err_set  = (r_state == S_WAIT_READY) && cfg_enable && w_ok && w_cfg_bad;
  assign sched_state = r_state;

  always_comb begin
    w_dl_cross = '0;
    w_ul_cross = '0;
    w_dl_zero  = '0;
    w_ul_zero  = '0;
    w_cfg_bad  = 1'b0;
    for (int c = 0; c < N_CARRIERS; c++) begin
      w_dl_sat[c]   = f_sat(cfg_dl_offset[c*OFS_W +: OFS_W]);
      w_ul_sat[c]   = f_sat(cfg_ul_offset[c*OFS_W +: OFS_W]);
      w_cfg_bad     = w_cfg_bad
                    | ({1'b0, cfg_dl_offset[c*OFS_W +: OFS_W]} >= W_FRAME)
                    | ({1'b0, cfg_ul_offset[c*OFS_W +: OFS_W]} >= W_FRAME);
      w_dl_cross[c] = f_cross(r_frame_ns, w_next, r_dl_ofs[c]);
      w_ul_cross[c] = f_cross(r_frame_ns, w_next, r_ul_ofs[c]);
      w_dl_zero[c]  = (r_dl_ofs[c] == '0);
      w_ul_zero[c]  = (r_ul_ofs[c] == '0);
    end
  end

  // Crossing hits are registered on the phase update and emitted one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_pps_d             <= 1'b0;
      r_frame_ns          <= '0;
      r_dl_hit            <= '0;
      r_ul_hit            <= '0;
      dl_radio_start_10ms <= '0;
      ul_radio_start_10ms <= '0;
      frame_cnt           <= '0;
      pps_slip            <= 1'b0;
      cfg_err             <= 1'b0;
      for (int c = 0; c < N_CARRIERS; c++) begin
        r_dl_ofs[c] <= '0;
        r_ul_ofs[c] <= '0;
      end
    end else begin
      r_pps_d             <= one_pps;
      r_dl_hit            <= '0;
      r_ul_hit            <= '0;
      dl_radio_start_10ms <= '0;
      ul_radio_start_10ms <= '0;

      if (w_slip_set)      pps_slip <= 1'b1;
      else if (sticky_clr) pps_slip <= 1'b0;
      if (w_err_set)       cfg_err  <= 1'b1;
      else if (sticky_clr) cfg_err  <= 1'b0;

      if (!cfg_enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_READY;
          S_WAIT_READY: begin
            if (w_ok) begin
              r_state <= S_WAIT_PPS;
              for (int c = 0; c < N_CARRIERS; c++) begin
                r_dl_ofs[c] <= w_dl_sat[c];
                r_ul_ofs[c] <= w_ul_sat[c];
              end
            end
          end
          S_WAIT_PPS: begin
            if (!w_ok) begin
              r_state <= S_WAIT_READY;
            end else if (w_pps_edge) begin
              r_state    <= S_RUN;
              r_frame_ns <= '0;
              frame_cnt  <= '0;
              r_dl_hit   <= w_dl_zero;
              r_ul_hit   <= w_ul_zero;
            end
          end
          S_RUN: begin
            if (!w_ok) begin
              r_state <= S_WAIT_READY;
            end else begin
              r_frame_ns          <= w_next;
              r_dl_hit            <= w_dl_cross;
              r_ul_hit            <= w_ul_cross;
              dl_radio_start_10ms <= r_dl_hit & cfg_carrier_en;
              ul_radio_start_10ms <= r_ul_hit & cfg_carrier_en;
              if (w_wrap || w_pps_edge) frame_cnt <= frame_cnt + 10'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jb_fh_radio_frame_sched.sv
// Bench for jb_fh_radio_frame_sched: directed bring-up scenarios plus randomized
// traffic, all checked against a phase-arithmetic reference model.
module tb_jb_fh_radio_frame_sched;

  localparam int F    = 1000;
  localparam int STEP = 4;
  localparam int NC   = 2;
  localparam int OW   = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_enable;
  logic [NC-1:0]    cfg_carrier_en;
  logic [OW-1:0]    dl_in [NC];
  logic [OW-1:0]    ul_in [NC];
  logic [NC*OW-1:0] cfg_dl_offset;
  logic [NC*OW-1:0] cfg_ul_offset;
  logic             sticky_clr;
  logic             one_pps;
  logic [1:0]       eth_fram_reset_active;
  logic             ul_fram_ready;
  logic             dl_defm_ready;
  logic [NC-1:0]    dl_radio_start_10ms;
  logic [NC-1:0]    ul_radio_start_10ms;
  logic [9:0]       frame_cnt;
  logic [1:0]       sched_state;
  logic             pps_slip;
  logic             cfg_err;

  assign cfg_dl_offset = {dl_in[1], dl_in[0]};
  assign cfg_ul_offset = {ul_in[1], ul_in[0]};

  jb_fh_radio_frame_sched #(
    .N_CARRIERS(NC), .N_ETH_PORTS(2), .NS_PER_CLK(STEP), .FRAME_NS(F), .OFS_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_carrier_en(cfg_carrier_en),
    .cfg_dl_offset(cfg_dl_offset), .cfg_ul_offset(cfg_ul_offset), .sticky_clr(sticky_clr),
    .one_pps(one_pps), .eth_fram_reset_active(eth_fram_reset_active),
    .ul_fram_ready(ul_fram_ready), .dl_defm_ready(dl_defm_ready),
    .dl_radio_start_10ms(dl_radio_start_10ms), .ul_radio_start_10ms(ul_radio_start_10ms),
    .frame_cnt(frame_cnt), .sched_state(sched_state), .pps_slip(pps_slip), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  // Reference model: frame phase in ns, strobe due when an offset lies in (p, n] mod F.
  int      m_state, m_ph, m_cnt, m_p, m_n;
  int      m_dl_o [NC];
  int      m_ul_o [NC];
  bit      m_pps_d, m_slip, m_err, m_edge, m_ok, m_slip_set, m_err_set;
  bit [NC-1:0] m_dl_pend, m_ul_pend, m_nd, m_nu, exp_dl, exp_ul;

  function automatic bit crosses(input int p, input int n, input int o);
    int d;
    d = (n - p + F) % F;
    if (d == 0) d = F;
    return ((o - p - 1 + F) % F) < d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_ph = 0; m_cnt = 0; m_pps_d = 0; m_slip = 0; m_err = 0;
      m_dl_pend = '0; m_ul_pend = '0; exp_dl = '0; exp_ul = '0;
      for (int c = 0; c < NC; c++) begin m_dl_o[c] = 0; m_ul_o[c] = 0; end
    end else begin
      m_edge = one_pps && !m_pps_d;
      m_pps_d = one_pps;
      m_ok = dl_defm_ready && ul_fram_ready && (eth_fram_reset_active == 2'b00);
      m_nd = '0; m_nu = '0; exp_dl = '0; exp_ul = '0;
      m_slip_set = 0; m_err_set = 0;
      if (!cfg_enable) m_state = 0;
      else case (m_state)
        0: m_state = 1;
        1: if (m_ok) begin
             m_state = 2;
             for (int c = 0; c < NC; c++) begin
               if (int'(dl_in[c]) >= F) begin m_err_set = 1; m_dl_o[c] = F - STEP; end
               else m_dl_o[c] = int'(dl_in[c]);
               if (int'(ul_in[c]) >= F) begin m_err_set = 1; m_ul_o[c] = F - STEP; end
               else m_ul_o[c] = int'(ul_in[c]);
             end
           end
        2: if (!m_ok) m_state = 1;
           else if (m_edge) begin
             m_state = 3; m_ph = 0; m_cnt = 0;
             for (int c = 0; c < NC; c++) begin
               m_nd[c] = (m_dl_o[c] == 0);
               m_nu[c] = (m_ul_o[c] == 0);
             end
           end
        default: if (!m_ok) m_state = 1;
           else begin
             m_p = m_ph;
             m_n = m_edge ? 0 : (m_p + STEP) % F;
             if (m_edge && m_p != F - STEP) m_slip_set = 1;
             if (m_edge || m_p + STEP >= F) m_cnt = (m_cnt + 1) % 1024;
             for (int c = 0; c < NC; c++) begin
               m_nd[c] = crosses(m_p, m_n, m_dl_o[c]);
               m_nu[c] = crosses(m_p, m_n, m_ul_o[c]);
             end
             exp_dl = m_dl_pend & cfg_carrier_en;
             exp_ul = m_ul_pend & cfg_carrier_en;
             m_ph = m_n;
           end
      endcase
      m_dl_pend = m_nd;
      m_ul_pend = m_nu;
      if (m_slip_set) m_slip = 1; else if (sticky_clr) m_slip = 0;
      if (m_err_set)  m_err  = 1; else if (sticky_clr) m_err  = 0;
    end
  end

  // Advance one clk, then compare every output against the model.
  task automatic step();
    @(posedge clk);
    #1;
    check("dl_strobe", 32'(dl_radio_start_10ms), 32'(exp_dl));
    check("ul_strobe", 32'(ul_radio_start_10ms), 32'(exp_ul));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    check("state", 32'(sched_state), 32'(m_state));
    check("pps_slip", 32'(pps_slip), 32'(m_slip));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int k, n_dl0, n_dl1, n_any, pps_timer;

  initial begin
    rst = 1; cfg_enable = 0; cfg_carrier_en = '0; sticky_clr = 0; one_pps = 0;
    eth_fram_reset_active = 2'b00; ul_fram_ready = 0; dl_defm_ready = 0;
    for (int c = 0; c < NC; c++) begin dl_in[c] = '0; ul_in[c] = '0; end
    steps(2);
    rst = 0;
    step();
    check("reset_state", 32'(sched_state), 32'd0);
    check("reset_cnt", 32'(frame_cnt), 32'd0);

    // Bring-up
    cfg_enable = 1; ul_fram_ready = 1; dl_defm_ready = 1; cfg_carrier_en = 2'b01;
    dl_in[0] = 24'd0; ul_in[0] = 24'd200; dl_in[1] = 24'd500; ul_in[1] = 24'd700;
    steps(4);
    check("wait_pps", 32'(sched_state), 32'd2);
    one_pps = 1;
    step();
    check("run_entry", 32'(sched_state), 32'd3);
    step();
    check("dl_first", 32'(dl_radio_start_10ms[0]), 32'd1);
    one_pps = 0;
    k = 0;
    while (k < 60) begin step(); k++; if (ul_radio_start_10ms[0]) break; end
    check("ul_gap", 32'(k), 32'd50);
    k = 0;
    while (k < 300) begin step(); k++; if (dl_radio_start_10ms[0]) break; end
    check("dl_period", 32'(k), 32'd200);
    check("cnt_after_wrap", 32'(frame_cnt), 32'd1);

    // PPS slip mid-frame
    steps(124);
    one_pps = 1;
    step();
    check("slip_set", 32'(pps_slip), 32'd1);
    step();
    check("realign_pulse", 32'(dl_radio_start_10ms[0]), 32'd1);
    one_pps = 0; sticky_clr = 1;
    step();
    sticky_clr = 0;
    check("slip_clr", 32'(pps_slip), 32'd0);

    // Readiness drop
    steps(37);
    eth_fram_reset_active = 2'b01;
    step();
    check("drop_state", 32'(sched_state), 32'd1);
    n_any = 0;
    for (int i = 0; i < 100; i++) begin step(); n_any += (dl_radio_start_10ms != 0 || ul_radio_start_10ms != 0); end
    eth_fram_reset_active = 2'b00;
    for (int i = 0; i < 300; i++) begin step(); n_any += (dl_radio_start_10ms != 0 || ul_radio_start_10ms != 0); end
    check("no_strobe_drop", 32'(n_any), 32'd0);
    check("needs_new_pps", 32'(sched_state), 32'd2);

    // Offset saturation
    cfg_enable = 0;
    step();
    dl_in[1] = 24'd1200; cfg_carrier_en = 2'b11; cfg_enable = 1;
    steps(3);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    one_pps = 1;
    step();
    one_pps = 0;
    step();
    check("dl0_entry", 32'(dl_radio_start_10ms[0]), 32'd1);
    k = 0;
    while (k < 300) begin step(); k++; if (dl_radio_start_10ms[1]) break; end
    check("sat_gap", 32'(k), 32'd249);
    cfg_carrier_en = 2'b01;
    n_dl0 = 0; n_dl1 = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      n_dl0 += int'(dl_radio_start_10ms[0]);
      n_dl1 += int'(dl_radio_start_10ms[1]);
    end
    check("dl0_continues", 32'(n_dl0), 32'd1);
    check("dl1_masked", 32'(n_dl1), 32'd0);

    // Disable and reset mid-RUN
    cfg_enable = 0;
    step();
    check("disable_idle", 32'(sched_state), 32'd0);
    check("disable_quiet", 32'({dl_radio_start_10ms, ul_radio_start_10ms}), 32'd0);
    cfg_enable = 1;
    steps(3);
    one_pps = 1;
    step();
    one_pps = 0;
    steps(300);
    check("cnt_before_rst", 32'(frame_cnt), 32'd1);
    rst = 1;
    step();
    rst = 0;
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_state", 32'(sched_state), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);

    // Randomized traffic
    pps_timer = 0;
    for (int i = 0; i < 6000; i++) begin
      if (pps_timer > 0) pps_timer--;
      else if ($urandom_range(0, 199) == 0) pps_timer = $urandom_range(1, 8);
      one_pps = (pps_timer > 0);
      rst = ($urandom_range(0, 2999) == 0);
      if (cfg_enable) cfg_enable = ($urandom_range(0, 999) != 0);
      else            cfg_enable = ($urandom_range(0, 19) == 0);
      if (eth_fram_reset_active != 0) begin
        if ($urandom_range(0, 9) == 0) eth_fram_reset_active = 2'b00;
      end else if ($urandom_range(0, 599) == 0) eth_fram_reset_active = 2'($urandom_range(1, 3));
      ul_fram_ready = ($urandom_range(0, 999) != 0);
      dl_defm_ready = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 99) == 0) cfg_carrier_en = 2'($urandom);
      if ($urandom_range(0, 199) == 0)
        for (int c = 0; c < NC; c++) begin
          dl_in[c] = 24'($urandom_range(0, 1100));
          ul_in[c] = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(0, 1100));
        end
      sticky_clr = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jb_fh_radio_frame_sched.md
Name: jb_fh_radio_frame_sched

Overview:
- Generates the per-carrier 10 ms radio-frame start strobes that the fronthaul consumes (dl_radio_start_10ms, ul_radio_start_10ms).
- Frame phase is locked to the fronthaul 1PPS.
- Strobes are released only when the fronthaul reports DL deframer ready, UL framer ready and no Ethernet framer reset.
- Sits on the LPHY side of the fronthaul misc interface, between register config and the FH timing inputs.

Parameters:
- N_CARRIERS, 2: number of carriers (strobe vector width).
- N_ETH_PORTS, 2: width of eth_fram_reset_active.
- NS_PER_CLK, 4: ns added to frame phase per clk.
- FRAME_NS, 10000000: frame length in ns; must be a multiple of NS_PER_CLK.
- OFS_W, 24: per-carrier offset width; 2**OFS_W > FRAME_NS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_enable  in  1  scheduler enable.
- cfg_carrier_en  in  N_CARRIERS  per-carrier strobe enable (live, not latched).
- cfg_dl_offset  in  N_CARRIERS*OFS_W  DL strobe phase in ns per carrier; carrier c at bits [c*OFS_W +: OFS_W].
- cfg_ul_offset  in  N_CARRIERS*OFS_W  UL strobe phase in ns per carrier.
- sticky_clr  in  1  clears pps_slip and cfg_err.
- one_pps  in  1  1PPS level from FH.
- eth_fram_reset_active  in  N_ETH_PORTS  Ethernet framer reset per port.
- ul_fram_ready  in  1  UL framer ready.
- dl_defm_ready  in  1  DL deframer ready.
- dl_radio_start_10ms  out  N_CARRIERS  one-clk DL frame-start pulses.
- ul_radio_start_10ms  out  N_CARRIERS  one-clk UL frame-start pulses.
- frame_cnt  out  10  frame counter.
- sched_state  out  2  state: 0 IDLE, 1 WAIT_READY, 2 WAIT_PPS, 3 RUN.
- pps_slip  out  1  sticky: PPS edge arrived off the frame boundary.
- cfg_err  out  1  sticky: an offset was >= FRAME_NS.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - all strobes 0, frame_cnt 0, sched_state IDLE, pps_slip 0, cfg_err 0;
  - internal frame_ns 0, pps_d 0.
- PPS edge: pps_edge = one_pps & ~pps_d, with pps_d registered every clk.
- ok = dl_defm_ready & ul_fram_ready & ~|eth_fram_reset_active.
- State machine, evaluated every clk; the cfg_enable=0 rule has priority over all others:
  - any state, cfg_enable=0 -> IDLE.
  - IDLE, cfg_enable=1 -> WAIT_READY.
  - WAIT_READY, ok=1 -> WAIT_PPS. On this transition, latch both offset vectors into shadow registers.
  - Offset saturation at latch time: any offset >= FRAME_NS is saturated to FRAME_NS-NS_PER_CLK and sets cfg_err.
  - WAIT_PPS, ok=0 -> WAIT_READY.
  - WAIT_PPS, pps_edge=1 -> RUN, with frame_ns<=0 and frame_cnt<=0.
  - RUN, ok=0 -> WAIT_READY. No strobes are emitted from that clk onward.
- frame_ns (valid in RUN only):
  - next value n = 0 on pps_edge;
  - otherwise n = p+NS_PER_CLK, wrapping to 0 when the sum reaches FRAME_NS.
  - frame_cnt increments modulo 1024 on every natural wrap or in-RUN pps_edge.
- PPS slip: a pps_edge in RUN with p != FRAME_NS-NS_PER_CLK sets pps_slip. frame_ns still realigns to 0.
- Crossing test, per shadow offset o, on a RUN update p->n:
  - fire if p < o <= n when n > p;
  - fire if o > p or o <= n when n <= p (wrap or realign).
  - On RUN entry from WAIT_PPS, only o=0 fires.
- Strobe gating and latency:
  - strobe bit c is the registered crossing result AND cfg_carrier_en[c];
  - the pulse is high the clk after the frame_ns update, for exactly one clk;
  - DL and UL are independent; equal offsets pulse in the same clk.
- Strobes are 0 in every state other than RUN, and in the clk a RUN exit is decided.
- Sticky flags:
  - sticky_clr clears both flags;
  - a set event in the same clk as sticky_clr wins (flag stays 1).
- rst at any time returns everything to reset values on the next clk.

Test Plan:
Bench setting for all cases: FRAME_NS=1000, NS_PER_CLK=4 (250 clk/frame).
- Bring-up: enable=1, ready pair=1, eth reset=0, dl_offset[0]=0, ul_offset[0]=200, carrier_en=1; one_pps rises at clk T.
  -> state RUN at T+1; dl[0] pulses at T+2, ul[0] at T+52, then both every 250 clk; frame_cnt=1 after the first wrap.
- Readiness drop: eth_fram_reset_active=2'b01 mid-frame.
  -> state WAIT_READY next clk, no further strobes; re-entering RUN requires the ready condition plus a new PPS edge.
- PPS slip: in RUN, one_pps edge when frame_ns=500.
  -> pps_slip=1, frame_ns realigns to 0, offset-0 carrier pulses next clk; sticky_clr -> pps_slip=0.
- Offset config: dl_offset[1]=1200.
  -> cfg_err=1, saturated to 996, dl[1] pulses 1 clk after frame_ns reaches 996; carrier_en[1]=0 suppresses it while carrier 0 continues.
- Disable/reset mid-RUN: cfg_enable=0.
  -> IDLE next clk, strobes 0; separately rst=1 for 1 clk -> all outputs reset values, frame_cnt=0.
